led_pattern_gen: RTL and testbench

//   Multi-channel LED driver, parametrised successor of the single fixed-rate blinker.
//   One shared prescaler tick drives N_CH independent channels.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_channel.sv | 113 +++++++++++
 rtl/led_pattern_gen.sv | 100 ++++++++++
 tb/tb_led_pattern_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: channel modes and the per-channel
// configuration record at the default field widths.
package led_pkg;

    localparam int LED_PER_W = 16;
    localparam int LED_CNT_W = 8;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } led_mode_e;

    typedef struct packed {
        led_mode_e              mode;
        logic [LED_PER_W-1:0]   half;
        logic [LED_CNT_W-1:0]   count;
    } led_cfg_t;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode, half-period, phase counter and remaining burst
// pulses, and advances the pattern on each prescaler tick.
module led_channel
    import led_pkg::*;
#(
    parameter int  PER_W = LED_PER_W,
    parameter int  CNT_W = LED_CNT_W,
    parameter type cfg_t = led_cfg_t
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic load_i,
    input  cfg_t cfg_i,
    output logic led_o,
    output logic busy_o
);

    led_mode_e          mode_q, mode_d;
    logic [PER_W-1:0]   half_q, half_d;
    logic [PER_W-1:0]   ph_q, ph_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               ph_wrap;

    assign ph_wrap = (ph_q == half_q - PER_W'(1));

    always_comb begin
        mode_d = mode_q;
        half_d = half_q;
        ph_d   = ph_q;
        rem_d  = rem_q;
        led_d  = led_q;
        busy_d = busy_q;
        // A load takes priority over a tick arriving in the same cycle.
        if (load_i) begin
            mode_d = cfg_i.mode;
            half_d = (cfg_i.half == '0) ? PER_W'(1) : cfg_i.half;
            ph_d   = '0;
            rem_d  = cfg_i.count;
            case (cfg_i.mode)
                LED_ON, LED_BLINK: begin
                    led_d  = 1'b1;
                    busy_d = 1'b0;
                end
                LED_BURST: begin
                    led_d  = (cfg_i.count != '0);
                    busy_d = (cfg_i.count != '0);
                end
                default: begin
                    led_d  = 1'b0;
                    busy_d = 1'b0;
                end
            endcase
        end else if (tick_i) begin
            case (mode_q)
                LED_BLINK: begin
                    if (ph_wrap) begin
                        led_d = ~led_q;
                        ph_d  = '0;
                    end else begin
                        ph_d  = ph_q + PER_W'(1);
                    end
                end
                LED_BURST: begin
                    // Each pulse is a lit half followed by a dark half; the pulse
                    // is retired at the end of its dark half.
                    if (busy_q) begin
                        if (ph_wrap) begin
                            ph_d = '0;
                            if (led_q) begin
                                led_d = 1'b0;
                            end else begin
                                rem_d = rem_q - CNT_W'(1);
                                if (rem_q == CNT_W'(1)) begin
                                    busy_d = 1'b0;
                                end else begin
                                    led_d  = 1'b1;
                                end
                            end
                        end else begin
                            ph_d = ph_q + PER_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= LED_OFF;
            half_q <= '0;
            ph_q   <= '0;
            rem_q  <= '0;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            half_q <= half_d;
            ph_q   <= ph_d;
            rem_q  <= rem_d;
            led_q  <= led_d;
            busy_q <= busy_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler tick, a two-cycle config capture/apply
// path and one led_channel per LED.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000,
    parameter int N_CH    = 4,
    parameter int PER_W   = 16,
    parameter int CNT_W   = 8,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  led_mode_e        cfg_mode,
    input  logic [PER_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_count,
    output logic [N_CH-1:0]  led,
    output logic [N_CH-1:0]  busy,
    output logic             tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
    end

    // Config record sized to this instance's field widths.
    typedef struct packed {
        led_mode_e          mode;
        logic [PER_W-1:0]   half;
        logic [CNT_W-1:0]   count;
    } cfg_t;

    logic [DIV_W-1:0] div_q, div_d;
    logic             ready_q, ready_d;
    logic             apply_q, apply_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    cfg_t             cfg_q, cfg_d;
    logic             accept;

    assign tick   = (div_q == DIV_W'(DIV - 1));
    assign div_d  = tick ? '0 : div_q + DIV_W'(1);
    assign accept = cfg_valid && ready_q;

    // Ready drops for the apply cycle only, so writes land at most every other cycle.
    always_comb begin
        ready_d = ~accept;
        apply_d = accept;
        ch_d    = ch_q;
        cfg_d   = cfg_q;
        if (accept) begin
            ch_d  = cfg_ch;
            cfg_d = '{mode: cfg_mode, half: cfg_half, count: cfg_count};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            ready_q <= 1'b0;
            apply_q <= 1'b0;
            ch_q    <= '0;
            cfg_q   <= '0;
        end else begin
            div_q   <= div_d;
            ready_q <= ready_d;
            apply_q <= apply_d;
            ch_q    <= ch_d;
            cfg_q   <= cfg_d;
        end
    end

    assign cfg_ready = ready_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic load;
        assign load = apply_q && (ch_q == CH_W'(i));

        led_channel #(
            .PER_W (PER_W),
            .CNT_W (CNT_W),
            .cfg_t (cfg_t)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick_i (tick),
            .load_i (load),
            .cfg_i  (cfg_q),
            .led_o  (led[i]),
            .busy_o (busy[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: prescaler timing, config handshake, every
// channel mode and the apply/tick, reconfigure and reset corner cases.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 10;
    localparam int N_CH    = 3;
    localparam int PER_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CH_W    = 2;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch    = '0;
    led_mode_e        cfg_mode  = LED_OFF;
    logic [PER_W-1:0] cfg_half  = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [N_CH-1:0]  led;
    logic [N_CH-1:0]  busy;
    logic             tick;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    led_pattern_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .N_CH    (N_CH),
        .PER_W   (PER_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_half  (cfg_half),
        .cfg_count (cfg_count),
        .led       (led),
        .busy      (busy),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; cyc_n counts edges since the last reset release.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Advance to just after the edge that consumes the next prescaler tick.
    task automatic next_tick();
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (cyc_n % 10 == 0) break;
        end
    endtask

    // Full write: accept edge, apply cycle, returns in the first cycle after apply.
    task automatic cfg_write(input int ch, input led_mode_e m, input int h, input int c);
        chk("ready_before_write", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_mode  = m;
        cfg_half  = PER_W'(h);
        cfg_count = CNT_W'(c);
        cyc();
        cfg_valid = 1'b0;
        chk("ready_low_in_apply", cfg_ready, 0);
        cyc();
    endtask

    initial begin
        logic [2:0] burst_led [5];
        logic [2:0] burst_busy[5];
        burst_led  = '{3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
        burst_busy = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000};

        // 1. reset values, ready timing, prescaler period
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ready", cfg_ready, 0);
        rst   = 1'b0;
        cyc_n = 0;
        cyc();
        chk("ready_after_release", cfg_ready, 1);
        for (int i = 0; i < 24; i++) begin
            chk("tick_prescale", tick, (cyc_n % 10 == 9));
            cyc();
        end

        // 2. BLINK half=3 on channel 0
        cfg_write(0, LED_BLINK, 3, 0);
        chk("blink_start_led", led, 3'b001);
        chk("blink_start_busy", busy, 3'b000);
        for (int k = 1; k <= 6; k++) begin
            next_tick();
            chk("blink_led", led, ((k / 3) % 2 == 0) ? 3'b001 : 3'b000);
        end
        cfg_write(0, LED_OFF, 0, 0);
        chk("off_led", led, 3'b000);

        // 3. BURST count=2 half=1 on channel 1
        cfg_write(1, LED_BURST, 1, 2);
        chk("burst_load_led", led, 3'b010);
        chk("burst_load_busy", busy, 3'b010);
        for (int k = 0; k < 5; k++) begin
            next_tick();
            chk("burst_led", led, burst_led[k]);
            chk("burst_busy", busy, burst_busy[k]);
        end

        // 4. abort a burst with ON, then a held valid
        cfg_write(1, LED_BURST, 2, 3);
        chk("burst2_load_led", led, 3'b010);
        next_tick();
        chk("burst2_t1_led", led, 3'b010);
        next_tick();
        chk("burst2_t2_led", led, 3'b000);
        chk("burst2_t2_busy", busy, 3'b010);
        cfg_write(1, LED_ON, 0, 0);
        chk("abort_on_led", led, 3'b010);
        chk("abort_on_busy", busy, 3'b000);

        chk("hold_ready_pre", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_mode  = LED_ON;
        cyc();
        chk("hold_ready_apply1", cfg_ready, 0);
        cfg_ch = 2'd0;
        cyc();
        chk("hold_ready_back", cfg_ready, 1);
        chk("hold_led_first", led, 3'b110);
        cyc();
        cfg_valid = 1'b0;
        chk("hold_ready_apply2", cfg_ready, 0);
        chk("hold_led_pending", led, 3'b110);
        cyc();
        chk("hold_led_second", led, 3'b111);
        chk("hold_ready_end", cfg_ready, 1);

        // 5. half=0, BURST count=0, out-of-range channel, apply on a tick
        cfg_write(2, LED_BLINK, 0, 0);
        chk("half0_start", led, 3'b111);
        next_tick();
        chk("half0_t1", led, 3'b011);
        next_tick();
        chk("half0_t2", led, 3'b111);
        cfg_write(2, LED_OFF, 0, 0);
        chk("ch2_off", led, 3'b011);
        cfg_write(1, LED_BURST, 3, 0);
        chk("burst0_led", led, 3'b001);
        chk("burst0_busy", busy, 3'b000);
        next_tick();
        chk("burst0_busy_tick", busy, 3'b000);
        cfg_write(3, LED_ON, 5, 5);
        chk("ch3_led", led, 3'b001);
        chk("ch3_busy", busy, 3'b000);

        for (int i = 0; i < 10 && (cyc_n % 10) != 8; i++) cyc();
        chk("coinc_ready", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_mode  = LED_BLINK;
        cfg_half  = 4'd2;
        cfg_count = 4'd0;
        cyc();
        cfg_valid = 1'b0;
        chk("coinc_tick_in_apply", tick, 1);
        cyc();
        chk("coinc_load_led", led, 3'b101);
        next_tick();
        chk("coinc_t1_led", led, 3'b101);
        next_tick();
        chk("coinc_t2_led", led, 3'b001);

        // 6. asynchronous reset mid-pattern
        next_tick();
        chk("pre_rst_led", led, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_tick", tick, 0);
        chk("async_rst_ready", cfg_ready, 0);
        #10;
        rst   = 1'b0;
        cyc_n = 0;
        cyc();
        chk("rerelease_ready", cfg_ready, 1);
        chk("rerelease_led", led, 0);
        repeat (8) cyc();
        chk("rerelease_tick", tick, 1);
        repeat (25) cyc();
        chk("post_rst_led", led, 0);
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
